// File: rtl/run_ctrl_pkg.sv
// Shared types and default widths for the run sequencer.
package run_ctrl_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int CYC_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    STALL = 3'd3,
    DONE  = 3'd4
  } run_state_t;

endpackage

// File: rtl/run_ctrl_if.sv
// Harness handshake, decode inputs and PC control outputs of the run sequencer.
interface run_ctrl_if
  import run_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) ();

  logic             req;
  logic             ack;
  logic             halt_instr;
  logic             branch_taken;
  logic [PC_W-1:0]  branch_offset;
  logic             pc_reset;
  logic             pc_en;
  logic             pc_branch_en;
  logic [PC_W-1:0]  pc_offset;
  logic             busy;
  logic             timeout;
  logic [CYC_W-1:0] cycle_count;

  modport master (
    output req, halt_instr, branch_taken, branch_offset,
    input  ack, pc_reset, pc_en, pc_branch_en, pc_offset, busy, timeout, cycle_count
  );

  modport slave (
    input  req, halt_instr, branch_taken, branch_offset,
    output ack, pc_reset, pc_en, pc_branch_en, pc_offset, busy, timeout, cycle_count
  );

endinterface

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at MAX instead of wrapping.
module sat_counter #(
  parameter int           W   = 16,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_at_max
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_at_max = (r_count == MAX);

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: clears the PC on start, gates PC enable/branch until halt or cycle limit.
//
// state | meaning
// IDLE  | waiting for req; all PC controls low
// CLEAR | one cycle of PC clear, counters and timeout cleared
// RUN   | PC advancing; halt, limit and taken branches evaluated
// STALL | bubble cycles after a taken branch; PC held
// DONE  | ack high until the harness drops req
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int               PC_W     = PC_W_DEF,
  parameter int               CYC_W    = CYC_W_DEF,
  parameter int               BR_STALL = 1,
  parameter logic [CYC_W-1:0] MAX_CYC  = '1
) (
  input  logic      i_clk,
  input  logic      i_reset,
  run_ctrl_if.slave bus
);

  localparam logic [CYC_W-1:0] LAST_CYC   = MAX_CYC - 1'b1;
  localparam logic [1:0]       STALL_LOAD = 2'(BR_STALL - 1);

  run_state_t       r_state;
  run_state_t       w_next;
  logic [1:0]       r_stall_cnt;
  logic             r_timeout;
  logic             r_busy;
  logic             r_ack;
  logic [CYC_W-1:0] w_count;
  logic             w_at_max;
  logic             w_in_run;
  logic             w_halt;
  logic             w_branch;
  logic             w_inc;
  logic             w_last;

  assign w_in_run = (r_state == RUN);
  assign w_halt   = w_in_run && bus.halt_instr;
  assign w_branch = w_in_run && bus.branch_taken && !bus.halt_instr && !i_reset;
  // The halt cycle is not counted: the PC freezes on the halt address.
  assign w_inc    = ((w_in_run && !bus.halt_instr) || (r_state == STALL)) && !w_at_max;
  assign w_last   = (w_count == LAST_CYC);

  sat_counter #(
    .W   (CYC_W),
    .MAX (MAX_CYC)
  ) u_cyc_cnt (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clr    (r_state == CLEAR),
    .i_inc    (w_inc),
    .o_count  (w_count),
    .o_at_max (w_at_max)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (bus.req) w_next = CLEAR;
      CLEAR: w_next = RUN;
      RUN: begin
        if (bus.halt_instr)                     w_next = DONE;
        else if (w_last)                        w_next = DONE;
        else if (bus.branch_taken && BR_STALL > 0) w_next = STALL;
      end
      STALL: begin
        if (w_last)                 w_next = DONE;
        else if (r_stall_cnt == 2'd0) w_next = RUN;
      end
      DONE:    if (!bus.req) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_stall_cnt <= 2'd0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == CLEAR) || (w_next == RUN) || (w_next == STALL);
      r_ack   <= (w_next == DONE);

      if (r_state == CLEAR) begin
        r_timeout <= 1'b0;
      end else if (w_inc && w_last) begin
        r_timeout <= 1'b1;
      end

      if (w_in_run && w_next == STALL) begin
        r_stall_cnt <= STALL_LOAD;
      end else if (r_state == STALL && r_stall_cnt != 2'd0) begin
        r_stall_cnt <= r_stall_cnt - 2'd1;
      end
    end
  end

  assign bus.pc_reset     = i_reset || (r_state == CLEAR);
  assign bus.pc_en        = w_in_run && !w_halt && !i_reset;
  assign bus.pc_branch_en = w_branch;
  assign bus.pc_offset    = w_branch ? bus.branch_offset : PC_W'(0);
  assign bus.busy         = r_busy;
  assign bus.ack          = r_ack;
  assign bus.timeout      = r_timeout;
  assign bus.cycle_count  = w_count;

endmodule
